countdown_timer: RTL



---
 rtl/timer_pkg.sv | 24 ++
 rtl/bcd_down_digit.sv | 42 ++++
 rtl/countdown_timer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS countdown timer.
//   - timer_state_e : controller state encoding
//   - digit limit defaults and the BCD digit width
//   - bcd_clamp()   : saturates an operator-supplied digit to its legal maximum
package timer_pkg;

    localparam int DIGIT_W          = 4;
    localparam int DEF_MIN_TENS_MAX = 5;
    localparam int DEF_SEC_TENS_MAX = 5;
    localparam int DEF_ONES_MAX     = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_e;

    function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] v,
                                                     input logic [DIGIT_W-1:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit of the countdown chain.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (digit -> 0)
//   load       - write load_val (priority over dec_en)
//   load_val   - already-clamped value to load
//   dec_en     - borrow in: decrement this digit by one
//   digit      - registered digit value
//   borrow_out - combinational: this digit wraps, so the next digit must decrement
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter int WRAP = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               dec_en,
    output logic [DIGIT_W-1:0] digit,
    output logic               borrow_out
);

    logic [DIGIT_W-1:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (dec_en) begin
            digit_d = (digit_q == '0) ? DIGIT_W'(WRAP) : digit_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) digit_q <= '0;
        else     digit_q <= digit_d;
    end

    assign digit      = digit_q;
    assign borrow_out = dec_en && (digit_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer. Loads a start time, runs down one second per tick,
// can be paused and resumed, and pulses done for one cycle on reaching 00:00.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   tick                     - one-cycle 1 Hz enable
//   load, load_*             - load start time (clamped per digit), forces IDLE
//   start, pause             - level-sampled run/resume and pause requests
//   min_tens..sec_ones       - registered BCD digits
//   running, expired, done   - registered status; done is a one-cycle pulse
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MIN_TENS_MAX = DEF_MIN_TENS_MAX,
    parameter int SEC_TENS_MAX = DEF_SEC_TENS_MAX,
    parameter int ONES_MAX     = DEF_ONES_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_min_tens,
    input  logic [DIGIT_W-1:0] load_min_ones,
    input  logic [DIGIT_W-1:0] load_sec_tens,
    input  logic [DIGIT_W-1:0] load_sec_ones,
    input  logic               start,
    input  logic               pause,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               running,
    output logic               expired,
    output logic               done
);

    timer_state_e state_q, state_d;
    logic running_q, running_d;
    logic expired_q, expired_d;
    logic done_q, done_d;

    logic dec;
    logic b_so, b_st, b_mo, b_mt;
    logic is_zero, is_one;

    // Decrement only in RUN on a tick; load and pause both take precedence.
    assign dec = (state_q == ST_RUN) && tick && !pause && !load;

    bcd_down_digit #(.WRAP(ONES_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .load(load),
        .load_val(bcd_clamp(load_sec_ones, DIGIT_W'(ONES_MAX))),
        .dec_en(dec), .digit(sec_ones), .borrow_out(b_so)
    );

    bcd_down_digit #(.WRAP(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .load(load),
        .load_val(bcd_clamp(load_sec_tens, DIGIT_W'(SEC_TENS_MAX))),
        .dec_en(b_so), .digit(sec_tens), .borrow_out(b_st)
    );

    bcd_down_digit #(.WRAP(ONES_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .load(load),
        .load_val(bcd_clamp(load_min_ones, DIGIT_W'(ONES_MAX))),
        .dec_en(b_st), .digit(min_ones), .borrow_out(b_mo)
    );

    // WRAP is never exercised here: a decrement is only issued on a nonzero value.
    bcd_down_digit #(.WRAP(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .load(load),
        .load_val(bcd_clamp(load_min_tens, DIGIT_W'(MIN_TENS_MAX))),
        .dec_en(b_mo), .digit(min_tens), .borrow_out(b_mt)
    );

    assign is_zero = (min_tens == '0) && (min_ones == '0) &&
                     (sec_tens == '0) && (sec_ones == '0);
    assign is_one  = (min_tens == '0) && (min_ones == '0) &&
                     (sec_tens == '0) && (sec_ones == DIGIT_W'(1));

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:    if (start && !is_zero) state_d = ST_RUN;
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (dec && (is_one || b_mt)) begin
                        // This decrement lands on 00:00; b_mt would flag a
                        // chain underflow, which is treated as terminal too.
                        state_d = ST_EXPIRED;
                        done_d  = 1'b1;
                    end
                end
                ST_PAUSED:  if (start) state_d = ST_RUN;
                ST_EXPIRED: state_d = ST_EXPIRED;
                default:    state_d = ST_IDLE;
            endcase
        end
        running_d = (state_d == ST_RUN);
        expired_d = (state_d == ST_EXPIRED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            expired_q <= expired_d;
            done_q    <= done_d;
        end
    end

    assign running = running_q;
    assign expired = expired_q;
    assign done    = done_q;

endmodule
